// File: rtl/rst_sequencer.sv
// ============================================================================
//  Module   : rst_sequencer
//  Purpose  : Releases NumStages active-low reset domains in order after a
//             stretch and per-stage gap; supports a soft re-sequence request.
//  Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module rst_sequencer #(
   parameter int NumStages     = 3,
   parameter int StretchCycles = 4,
   parameter int GapCycles     = 2
) (
   input  logic                 clk_i,
   input  logic                 rst_ni,
   input  logic                 soft_rst_req_i,
   output logic                 soft_rst_ack_o,
   output logic [NumStages-1:0] stage_rst_no,
   output logic                 ready_o
);

   localparam int MaxCycles = (StretchCycles > GapCycles) ? StretchCycles : GapCycles;
   localparam int CntW      = $clog2(MaxCycles + 1);
   localparam int IdxW      = $clog2(NumStages + 1);

   if (NumStages < 1) begin : g_chk_stages
      $error("rst_sequencer: NumStages must be >= 1");
   end
   if (StretchCycles < 1) begin : g_chk_stretch
      $error("rst_sequencer: StretchCycles must be >= 1");
   end
   if (GapCycles < 1) begin : g_chk_gap
      $error("rst_sequencer: GapCycles must be >= 1");
   end

   typedef enum logic [1:0] {
      HOLD    = 2'd0,
      RELEASE = 2'd1,
      READY   = 2'd2
   } state_t;

   state_t               state, state_next;
   logic [CntW-1:0]      cnt, cnt_next;
   logic [IdxW-1:0]      idx, idx_next;
   logic [NumStages-1:0] stage_next;
   logic                 ready_next;
   logic                 ack_next;

   always_ff @(posedge clk_i) begin
      if (!rst_ni) begin
         state          <= HOLD;
         cnt            <= '0;
         idx            <= '0;
         stage_rst_no   <= '0;
         ready_o        <= 1'b0;
         soft_rst_ack_o <= 1'b0;
      end else begin
         state          <= state_next;
         cnt            <= cnt_next;
         idx            <= idx_next;
         stage_rst_no   <= stage_next;
         ready_o        <= ready_next;
         soft_rst_ack_o <= ack_next;
      end
   end

   // Outputs are computed here as next-state values so every port comes from a flop.
   always_comb begin
      state_next = state;
      cnt_next   = cnt;
      idx_next   = idx;
      stage_next = stage_rst_no;
      ready_next = 1'b0;
      ack_next   = 1'b0;
      case (state)
         HOLD: begin
            if (cnt == CntW'(StretchCycles - 1)) begin
               stage_next[0] = 1'b1;
               idx_next      = IdxW'(1);
               cnt_next      = '0;
               state_next    = (NumStages == 1) ? READY : RELEASE;
            end else begin
               cnt_next = cnt + CntW'(1);
            end
         end
         RELEASE: begin
            if (cnt == CntW'(GapCycles - 1)) begin
               for (int k = 0; k < NumStages; k++) begin
                  if (idx == IdxW'(k)) stage_next[k] = 1'b1;
               end
               idx_next = idx + IdxW'(1);
               cnt_next = '0;
               if (idx == IdxW'(NumStages - 1)) state_next = READY;
            end else begin
               cnt_next = cnt + CntW'(1);
            end
         end
         READY: begin
            if (soft_rst_req_i) begin
               stage_next = '0;
               ack_next   = 1'b1;
               cnt_next   = '0;
               idx_next   = '0;
               state_next = HOLD;
            end else begin
               ready_next = 1'b1;
            end
         end
         default: begin
            state_next = HOLD;
            cnt_next   = '0;
            idx_next   = '0;
            stage_next = '0;
         end
      endcase
   end

endmodule

`default_nettype wire
